// File: rtl/logicnets_input_quantizer_if.sv
// Single-beat valid/ready stream used on both sides of the input quantizer.
// The master drives valid/data/last; the slave drives ready.
interface logicnets_input_quantizer_if #(
   parameter int W = 16
) ();
   logic         valid;
   logic         ready;
   logic [W-1:0] data;
   logic         last;

   modport master (output valid, output data, output last, input ready);
   modport slave  (input valid, input data, input last, output ready);
endinterface

// File: rtl/logicnets_input_quantizer.sv
// Quantizes signed readout features to BITS-wide codes and packs NUM_FEAT of them
// into one double-buffered frame for the layer-0 LUTs.
//
// state   | meaning
// COLLECT | assembling features of the current shot into the assembly register
// DRAIN   | frame overran NUM_FEAT beats; discard beats up to and including s_last
module logicnets_input_quantizer #(
   parameter int NUM_FEAT = 8,
   parameter int IN_W     = 16,
   parameter int BITS     = 2,
   parameter int OFFSET   = 0,
   parameter int SHIFT    = 8
) (
   input  logic                        clk,
   input  logic                        rst,
   logicnets_input_quantizer_if.slave  s,
   logicnets_input_quantizer_if.master m,
   output logic                        err_pulse
);
   localparam int FW = NUM_FEAT * BITS;
   localparam int IW = (NUM_FEAT > 1) ? $clog2(NUM_FEAT) : 1;
   localparam logic [IW-1:0]          LAST_IDX = IW'(NUM_FEAT - 1);
   localparam logic signed [IN_W:0]   OFF_EXT  = (IN_W + 1)'(OFFSET);
   localparam logic signed [IN_W:0]   CODE_MAX = (IN_W + 1)'((1 << BITS) - 1);

   typedef enum logic {COLLECT, DRAIN} state_t;

   state_t            state;
   logic [IW-1:0]     idx;
   logic [FW-1:0]     asm_data;
   logic              asm_full;
   logic [FW-1:0]     out_data;
   logic              out_valid;

   logic signed [IN_W:0] d;
   logic signed [IN_W:0] q;
   logic [BITS-1:0]      code;
   logic [FW-1:0]        asm_next;
   logic                 accept;
   logic                 consume;

   always_comb begin
      d = $signed({s.data[IN_W-1], s.data}) - OFF_EXT;
      q = d >>> SHIFT;
      if (q < 0)
         code = '0;
      else if (q > CODE_MAX)
         code = CODE_MAX[BITS-1:0];
      else
         code = q[BITS-1:0];
      asm_next = asm_data;
      asm_next[idx*BITS +: BITS] = code;
   end

   assign accept  = s.valid && !asm_full;
   assign consume = out_valid && m.ready;

   assign s.ready = !asm_full;
   assign m.valid = out_valid;
   assign m.data  = out_data;
   assign m.last  = 1'b1;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= COLLECT;
         idx       <= '0;
         asm_data  <= '0;
         asm_full  <= 1'b0;
         out_data  <= '0;
         out_valid <= 1'b0;
         err_pulse <= 1'b0;
      end else begin
         err_pulse <= 1'b0;

         if (consume) begin
            if (asm_full) begin
               out_data <= asm_data;
               asm_full <= 1'b0;
            end else begin
               out_valid <= 1'b0;
            end
         end

         // accept implies the assembly register is empty, so a completed frame
         // never collides with the asm->out transfer above
         if (accept) begin
            case (state)
               COLLECT: begin
                  if (idx == LAST_IDX) begin
                     idx <= '0;
                     if (s.last) begin
                        if (!out_valid || consume) begin
                           out_data  <= asm_next;
                           out_valid <= 1'b1;
                        end else begin
                           asm_data <= asm_next;
                           asm_full <= 1'b1;
                        end
                     end else begin
                        state <= DRAIN;
                     end
                  end else if (s.last) begin
                     err_pulse <= 1'b1;
                     idx       <= '0;
                  end else begin
                     asm_data <= asm_next;
                     idx      <= idx + IW'(1);
                  end
               end
               DRAIN: begin
                  if (s.last) begin
                     err_pulse <= 1'b1;
                     idx       <= '0;
                     state     <= COLLECT;
                  end
               end
               default: state <= COLLECT;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_logicnets_input_quantizer.sv
// Directed and randomized checks of the LogicNets input quantizer with
// OFFSET=0, SHIFT=8, BITS=2, NUM_FEAT=8.
module tb_logicnets_input_quantizer;
   logic clk = 1'b0;
   logic rst;
   logic err_pulse;
   int   checks   = 0;
   int   failures = 0;

   logicnets_input_quantizer_if #(.W(16)) s_if ();
   logicnets_input_quantizer_if #(.W(16)) m_if ();

   logicnets_input_quantizer #(
      .NUM_FEAT(8), .IN_W(16), .BITS(2), .OFFSET(0), .SHIFT(8)
   ) dut (
      .clk(clk), .rst(rst), .s(s_if.slave), .m(m_if.master), .err_pulse(err_pulse)
   );

   always #5 clk = ~clk;

   // frame A -> codes [1,0,3,2,0,0,1,2]; frame B -> codes [0,3,1,3,3,0,2,1]
   logic signed [15:0] va [8] = '{16'sd300, -16'sd5, 16'sd2000, 16'sd512,
                                  16'sd0, 16'sd255, 16'sd256, 16'sd767};
   logic signed [15:0] vb [8] = '{-16'sd32768, 16'sd32767, 16'sd511, 16'sd768,
                                  16'sd1023, 16'sd100, 16'sd700, 16'sd256};
   localparam logic [15:0] FRAME_A = 16'h90B1;
   localparam logic [15:0] FRAME_B = 16'h63DC;

   logic [15:0] got_q [$];
   logic [15:0] exp_q [$];
   logic        prev_stall = 1'b0;
   logic [15:0] prev_data  = '0;

   // output monitor: log handshakes and hold m_data/m_valid during stalls
   always @(negedge clk) begin
      if (prev_stall && !rst) begin
         checks++;
         if (m_if.valid !== 1'b1 || m_if.data !== prev_data) begin
            failures++;
            $display("FAIL stall_stable valid=%b data=%h required valid=1 data=%h",
                     m_if.valid, m_if.data, prev_data);
         end
      end
      if (!rst && m_if.valid === 1'b1 && m_if.ready === 1'b1)
         got_q.push_back(m_if.data);
      prev_stall = !rst && m_if.valid === 1'b1 && m_if.ready === 1'b0;
      prev_data  = m_if.data;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_beat(input logic [15:0] data, input logic last);
      int   n = 0;
      logic rdy;
      bit   done = 0;
      s_if.valid = 1'b1;
      s_if.data  = data;
      s_if.last  = last;
      while (!done) begin
         rdy = s_if.ready;
         tick();
         if (rdy === 1'b1) done = 1;
         else if (++n > 300) begin
            checks++;
            failures++;
            $display("FAIL send_timeout s_ready stuck low, required a beat accept");
            done = 1;
         end
      end
      s_if.valid = 1'b0;
      s_if.last  = 1'b0;
   endtask

   task automatic send_a();
      for (int i = 0; i < 8; i++) send_beat(va[i], i == 7);
   endtask

   task automatic send_b();
      for (int i = 0; i < 8; i++) send_beat(vb[i], i == 7);
   endtask

   function automatic logic [1:0] quant(input logic signed [15:0] x);
      int v;
      v = (int'(x) - 0) >>> 8;
      if (v < 0) return 2'd0;
      if (v > 3) return 2'd3;
      return v[1:0];
   endfunction

   task automatic test_reset();
      rst = 1'b1;
      s_if.valid = 1'b0; s_if.data = '0; s_if.last = 1'b0; m_if.ready = 1'b0;
      tick(); tick();
      checks++; if (s_if.ready !== 1'b1) begin failures++; $display("FAIL reset_s_ready got=%b required=1", s_if.ready); end
      checks++; if (m_if.valid !== 1'b0) begin failures++; $display("FAIL reset_m_valid got=%b required=0", m_if.valid); end
      checks++; if (m_if.data !== 16'h0) begin failures++; $display("FAIL reset_m_data got=%h required=0000", m_if.data); end
      checks++; if (err_pulse !== 1'b0) begin failures++; $display("FAIL reset_err got=%b required=0", err_pulse); end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_basic();
      got_q.delete();
      m_if.ready = 1'b1;
      for (int i = 0; i < 7; i++) send_beat(va[i], 1'b0);
      checks++; if (m_if.valid !== 1'b0) begin failures++; $display("FAIL basic_early_valid got=%b required=0", m_if.valid); end
      send_beat(va[7], 1'b1);
      checks++; if (m_if.valid !== 1'b1) begin failures++; $display("FAIL basic_latency got=%b required=1", m_if.valid); end
      checks++; if (m_if.data !== FRAME_A) begin failures++; $display("FAIL basic_data got=%h required=%h", m_if.data, FRAME_A); end
      tick();
      checks++; if (m_if.valid !== 1'b0) begin failures++; $display("FAIL basic_after_consume got=%b required=0", m_if.valid); end
      checks++; if (got_q.size() != 1) begin failures++; $display("FAIL basic_count got=%0d required=1", got_q.size()); end
   endtask

   task automatic test_back_to_back();
      got_q.delete();
      m_if.ready = 1'b0;
      send_a();
      send_b();
      checks++; if (s_if.ready !== 1'b0) begin failures++; $display("FAIL b2b_s_ready_drop got=%b required=0", s_if.ready); end
      checks++; if (m_if.data !== FRAME_A || m_if.valid !== 1'b1) begin failures++; $display("FAIL b2b_hold_a got=%h/%b required=%h/1", m_if.data, m_if.valid, FRAME_A); end
      tick(); tick();
      m_if.ready = 1'b1;
      tick();
      checks++; if (m_if.valid !== 1'b1 || m_if.data !== FRAME_B) begin failures++; $display("FAIL b2b_second got=%h/%b required=%h/1", m_if.data, m_if.valid, FRAME_B); end
      checks++; if (s_if.ready !== 1'b1) begin failures++; $display("FAIL b2b_s_ready_return got=%b required=1", s_if.ready); end
      tick();
      checks++; if (m_if.valid !== 1'b0) begin failures++; $display("FAIL b2b_empty got=%b required=0", m_if.valid); end
      checks++;
      if (got_q.size() != 2 || got_q[0] !== FRAME_A || got_q[1] !== FRAME_B) begin
         failures++;
         $display("FAIL b2b_order got_n=%0d required=2 frames %h,%h", got_q.size(), FRAME_A, FRAME_B);
      end
   endtask

   task automatic test_short_frame();
      got_q.delete();
      m_if.ready = 1'b1;
      send_beat(va[0], 1'b0);
      send_beat(va[1], 1'b0);
      send_beat(va[2], 1'b1);
      checks++; if (err_pulse !== 1'b1) begin failures++; $display("FAIL short_err got=%b required=1", err_pulse); end
      tick();
      checks++; if (err_pulse !== 1'b0) begin failures++; $display("FAIL short_err_width got=%b required=0", err_pulse); end
      checks++; if (got_q.size() != 0) begin failures++; $display("FAIL short_no_frame got=%0d required=0", got_q.size()); end
      send_b();
      tick();
      checks++;
      if (got_q.size() != 1 || got_q[0] !== FRAME_B) begin
         failures++;
         $display("FAIL short_next_frame got_n=%0d required=1 frame %h", got_q.size(), FRAME_B);
      end
   endtask

   task automatic test_long_frame();
      got_q.delete();
      m_if.ready = 1'b1;
      for (int i = 0; i < 11; i++) begin
         send_beat(va[i % 8], i == 10);
         if (i < 10) begin
            checks++; if (err_pulse !== 1'b0) begin failures++; $display("FAIL long_early_err beat=%0d got=%b required=0", i, err_pulse); end
         end
      end
      checks++; if (err_pulse !== 1'b1) begin failures++; $display("FAIL long_err got=%b required=1", err_pulse); end
      tick();
      checks++; if (got_q.size() != 0) begin failures++; $display("FAIL long_no_frame got=%0d required=0", got_q.size()); end
      send_a();
      tick();
      checks++;
      if (got_q.size() != 1 || got_q[0] !== FRAME_A) begin
         failures++;
         $display("FAIL long_next_frame got_n=%0d required=1 frame %h", got_q.size(), FRAME_A);
      end
   endtask

   task automatic test_random();
      bit rand_on = 1;
      int n = 0;
      got_q.delete();
      exp_q.delete();
      fork
         begin
            for (int f = 0; f < 100; f++) begin
               logic [15:0] frame = '0;
               for (int k = 0; k < 8; k++) begin
                  logic signed [15:0] x;
                  if ($urandom_range(0, 9) == 0) x = 16'($urandom);
                  else x = 16'($urandom_range(0, 1535)) - 16'sd300;
                  frame[k*2 +: 2] = quant(x);
                  if ($urandom_range(0, 5) == 0) tick();
                  send_beat(x, k == 7);
               end
               exp_q.push_back(frame);
            end
            rand_on = 0;
         end
         begin
            while (rand_on) begin
               m_if.ready = 1'($urandom_range(0, 1));
               tick();
            end
         end
      join
      m_if.ready = 1'b1;
      while (got_q.size() < 100 && n < 50) begin tick(); n++; end
      checks++; if (got_q.size() != 100) begin failures++; $display("FAIL rand_count got=%0d required=100", got_q.size()); end
      for (int i = 0; i < 100; i++) begin
         if (i < got_q.size()) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL rand_frame idx=%0d got=%h required=%h", i, got_q[i], exp_q[i]); end
         end
      end
   endtask

   task automatic test_reset_mid_frame();
      got_q.delete();
      m_if.ready = 1'b0;
      send_a();
      for (int i = 0; i < 4; i++) send_beat(vb[i], 1'b0);
      s_if.valid = 1'b1; s_if.data = vb[4]; s_if.last = 1'b0;
      rst = 1'b1;
      tick();
      checks++; if (m_if.valid !== 1'b0) begin failures++; $display("FAIL rstmid_m_valid got=%b required=0", m_if.valid); end
      checks++; if (s_if.ready !== 1'b1) begin failures++; $display("FAIL rstmid_s_ready got=%b required=1", s_if.ready); end
      rst = 1'b0;
      s_if.valid = 1'b0;
      tick();
      got_q.delete();
      m_if.ready = 1'b1;
      send_b();
      tick();
      checks++;
      if (got_q.size() != 1 || got_q[0] !== FRAME_B) begin
         failures++;
         $display("FAIL rstmid_fresh_frame got_n=%0d required=1 frame %h", got_q.size(), FRAME_B);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_back_to_back();
      test_short_frame();
      test_long_frame();
      test_random();
      test_reset_mid_frame();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
